// File: rtl/ele_motion_ctrl.sv
// Elevator motion controller: a six-state FSM that moves a one-hot car
// position between four floors, opens the door at served floors and reports
// travel direction. Every output comes straight from a register.
module ele_motion_ctrl #(
  parameter int unsigned MOVE_TICKS = 64,  // cycles to travel one floor
  parameter int unsigned DOOR_TICKS = 96   // cycles the door stays open
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] upReq_reg,
  input  logic [3:0] downReq_reg,
  input  logic [3:0] inEleReq_reg,
  output logic [3:0] position,
  output logic [1:0] ud_mode,
  output logic       door_open,
  output logic       moving,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN_UP = 3'd1,
    S_RUN_DN = 3'd2,
    S_ARRIVE = 3'd3,
    S_DOOR   = 3'd4,
    S_DECIDE = 3'd5
  } state_e;

  localparam logic [1:0] UD_STOP = 2'b00;
  localparam logic [1:0] UD_UP   = 2'b01;
  localparam logic [1:0] UD_DN   = 2'b10;

  localparam logic [7:0] MOVE_LAST = 8'(MOVE_TICKS - 1);
  localparam logic [7:0] DOOR_LAST = 8'(DOOR_TICKS - 1);

  state_e     state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [1:0] ud_q, ud_d;
  logic       door_q, door_d;
  logic       mov_q, mov_d;
  logic [7:0] cnt_q, cnt_d;

  // Request views relative to the current floor. For a one-hot position,
  // pos-1 masks every lower floor and ~(pos | pos-1) every higher floor, so
  // the top floor has nothing above and the bottom floor nothing below.
  logic [3:0] all_req, above, below, here;
  logic [3:0] dir_req, opp_req, ahead, behind;
  logic       going_up;
  logic [1:0] ud_flip;

  assign all_req  = upReq_reg | downReq_reg | inEleReq_reg;
  assign below    = all_req & (pos_q - 4'd1);
  assign above    = all_req & ~(pos_q | (pos_q - 4'd1));
  assign here     = all_req & pos_q;
  assign going_up = (ud_q == UD_UP);
  assign ud_flip  = going_up ? UD_DN : UD_UP;
  assign dir_req  = going_up ? upReq_reg : downReq_reg;
  assign opp_req  = going_up ? downReq_reg : upReq_reg;
  assign ahead    = going_up ? above : below;
  assign behind   = going_up ? below : above;

  // Next-state, next-position, direction and tick counter.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pos_d   = pos_q;
    ud_d    = ud_q;
    cnt_d   = 8'd0;  // any state entered from another starts its count at 0

    case (state_q)
      S_IDLE: begin
        ud_d = UD_STOP;
        if (|here) begin
          state_d = S_DOOR;
          ud_d    = pos_q[3] ? UD_DN : UD_UP;
        end else if (|above) begin
          state_d = S_RUN_UP;
          ud_d    = UD_UP;
        end else if (|below) begin
          state_d = S_RUN_DN;
          ud_d    = UD_DN;
        end
      end

      S_RUN_UP, S_RUN_DN: begin
        if (cnt_q == MOVE_LAST) begin
          state_d = S_ARRIVE;
          if (state_q == S_RUN_UP) pos_d = pos_q[3] ? pos_q : (pos_q << 1);
          else                     pos_d = pos_q[0] ? pos_q : (pos_q >> 1);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_ARRIVE: begin
        if (|((inEleReq_reg | dir_req) & pos_q)) begin
          state_d = S_DOOR;
        end else if ((|(opp_req & pos_q)) && !(|ahead)) begin
          state_d = S_DOOR;
          ud_d    = ud_flip;
        end else begin
          state_d = S_DECIDE;
        end
      end

      S_DOOR: begin
        if (cnt_q == DOOR_LAST) state_d = S_DECIDE;
        else                    cnt_d   = cnt_q + 8'd1;
      end

      S_DECIDE: begin
        if (|ahead) begin
          state_d = going_up ? S_RUN_UP : S_RUN_DN;
        end else if (|here) begin
          state_d = S_DOOR;
          ud_d    = ud_flip;
        end else if (|behind) begin
          state_d = going_up ? S_RUN_DN : S_RUN_UP;
          ud_d    = ud_flip;
        end else begin
          state_d = S_IDLE;
          ud_d    = UD_STOP;
        end
      end

      default: begin
        state_d = S_IDLE;
        ud_d    = UD_STOP;
      end
    endcase

    // Door and motion flags follow the state being entered, so they can
    // never be high together.
    door_d = (state_d == S_DOOR);
    mov_d  = (state_d == S_RUN_UP) || (state_d == S_RUN_DN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q   <= 4'b0001;
      ud_q    <= UD_STOP;
      door_q  <= 1'b0;
      mov_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      ud_q    <= ud_d;
      door_q  <= door_d;
      mov_q   <= mov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign position  = pos_q;
  assign ud_mode   = ud_q;
  assign door_open = door_q;
  assign moving    = mov_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ele_motion_ctrl.sv
// Self-checking bench for ele_motion_ctrl: directed scenarios with literal
// expectations, then random requests checked every cycle against a
// floor-index behavioural model and an upstream request-latch model.
module tb_ele_motion_ctrl;

  localparam int MT      = 4;
  localparam int DT      = 3;
  localparam int AGE_MAX = 600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] up_r, dn_r, in_r;
  logic [3:0] d_pos;
  logic [1:0] d_ud;
  logic       d_door, d_mov;
  logic [2:0] d_state;
  logic [10:0] dut_vec;

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  cmp_en = 1'b0;

  // Model: floor as an integer, direction 0 stop / 1 up / 2 down, and a
  // count of cycles remaining in a timed phase.
  int m_st = 0, m_floor = 0, m_ud = 0, m_left = 0;

  always #5 clk = ~clk;

  ele_motion_ctrl #(.MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst_n(rst_n),
    .upReq_reg(up_r), .downReq_reg(dn_r), .inEleReq_reg(in_r),
    .position(d_pos), .ud_mode(d_ud), .door_open(d_door),
    .moving(d_mov), .state(d_state)
  );

  assign dut_vec = {d_state, d_pos, d_ud, d_door, d_mov};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] ov(input int st, input logic [3:0] p, input logic [1:0] u,
                                     input logic d, input logic m);
    return {st[2:0], p, u, d, m};
  endfunction

  function automatic logic [10:0] mdl_vec();
    logic [3:0] p;
    p = 4'b0001 << m_floor;
    return ov(m_st, p, m_ud[1:0], m_st == 4, (m_st == 1) || (m_st == 2));
  endfunction

  // True if any floor strictly beyond f in direction step has a request.
  function automatic bit any_beyond(input logic [3:0] v, input int f, input int step);
    int i;
    i = f + step;
    while (i >= 0 && i <= 3) begin
      if (v[i]) return 1'b1;
      i += step;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [3:0] all;
    int  dstep;
    bit  here, ahead, behind, stop_dir, stop_opp;
    if (!rst_n) begin
      m_st = 0; m_floor = 0; m_ud = 0; m_left = 0;
      return;
    end
    all    = up_r | dn_r | in_r;
    dstep  = (m_ud == 2) ? -1 : 1;
    here   = all[m_floor];
    ahead  = any_beyond(all, m_floor, dstep);
    behind = any_beyond(all, m_floor, -dstep);
    case (m_st)
      0: begin
        if (here) begin
          m_st = 4; m_ud = (m_floor == 3) ? 2 : 1; m_left = DT;
        end else if (any_beyond(all, m_floor, 1)) begin
          m_st = 1; m_ud = 1; m_left = MT;
        end else if (any_beyond(all, m_floor, -1)) begin
          m_st = 2; m_ud = 2; m_left = MT;
        end
      end
      1, 2: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += (m_st == 1) ? 1 : -1;
          if (m_floor > 3) m_floor = 3;
          if (m_floor < 0) m_floor = 0;
          m_st = 3;
        end
      end
      3: begin
        stop_dir = in_r[m_floor] | ((m_ud == 1) ? up_r[m_floor] : dn_r[m_floor]);
        stop_opp = (m_ud == 1) ? dn_r[m_floor] : up_r[m_floor];
        if (stop_dir) begin
          m_st = 4; m_left = DT;
        end else if (stop_opp && !ahead) begin
          m_st = 4; m_left = DT; m_ud = 3 - m_ud;
        end else begin
          m_st = 5;
        end
      end
      4: begin
        m_left--;
        if (m_left == 0) m_st = 5;
      end
      5: begin
        if (ahead) begin
          m_st = (m_ud == 1) ? 1 : 2; m_left = MT;
        end else if (here) begin
          m_ud = 3 - m_ud; m_st = 4; m_left = DT;
        end else if (behind) begin
          m_ud = 3 - m_ud; m_st = (m_ud == 1) ? 1 : 2; m_left = MT;
        end else begin
          m_st = 0; m_ud = 0;
        end
      end
      default: begin
        m_st = 0; m_ud = 0;
      end
    endcase
  endtask

  task automatic compare_outputs();
    if (!cmp_en) return;
    check("outputs_vs_model", dut_vec, mdl_vec());
    check("position_onehot", 32'($onehot(d_pos)), 32'd1);
    check("ud_mode_not_11", 32'(d_ud == 2'b11), 32'd0);
    check("door_and_moving", 32'(d_door & d_mov), 32'd0);
  endtask

  // Upstream latch: while the door is open, drop the in-car request and the
  // hall request matching the direction being served at that floor.
  task automatic upstream_clear();
    if (m_st == 4) begin
      in_r[m_floor] = 1'b0;
      if (m_ud == 1)      up_r[m_floor] = 1'b0;
      else if (m_ud == 2) dn_r[m_floor] = 1'b0;
    end
  endtask

  // One clock: model steps on the edge, outputs compared on the falling
  // edge, inputs updated just after.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
    #1;
    upstream_clear();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    up_r = '0; dn_r = '0; in_r = '0;
    tick();
    tick();
    check("reset_state", dut_vec, ov(0, 4'b0001, 2'b00, 1'b0, 1'b0));
  endtask

  task automatic wait_for(input int code, input int max, input string name);
    int n;
    n = 0;
    while (d_state !== 3'(code) && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(d_state), 32'(code));
  endtask

  function automatic logic [10:0] exp26(input int c);
    if (c < 4)   return ov(1, 4'b0001, 2'b01, 1'b0, 1'b1);
    if (c == 4)  return ov(3, 4'b0010, 2'b01, 1'b0, 1'b0);
    if (c == 5)  return ov(5, 4'b0010, 2'b01, 1'b0, 1'b0);
    if (c < 10)  return ov(1, 4'b0010, 2'b01, 1'b0, 1'b1);
    if (c == 10) return ov(3, 4'b0100, 2'b01, 1'b0, 1'b0);
    if (c < 14)  return ov(4, 4'b0100, 2'b01, 1'b1, 1'b0);
    if (c == 14) return ov(5, 4'b0100, 2'b01, 1'b0, 1'b0);
    return ov(0, 4'b0100, 2'b00, 1'b0, 1'b0);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int age [12];
    int max_age;
    logic [11:0] pend;
    int b, f;

    rst_n = 1'b0;
    up_r = '0; dn_r = '0; in_r = '0;
    tick();
    cmp_en = 1'b1;

    // Two-floor trip up to an in-car request, stopping once at the target.
    do_reset();
    in_r  = 4'b0100;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      check($sformatf("trip_up_c%0d", c), dut_vec, exp26(c));
      check($sformatf("trip_up_model_c%0d", c), mdl_vec(), exp26(c));
    end

    // Request at the current floor opens the door on the next cycle.
    do_reset();
    rst_n = 1'b1;
    tick();
    check("idle_floor0", dut_vec, ov(0, 4'b0001, 2'b00, 1'b0, 1'b0));
    up_r = 4'b0001;
    tick();
    check("door_at_floor0", dut_vec, ov(4, 4'b0001, 2'b01, 1'b1, 1'b0));
    wait_for(0, 20, "floor0_back_idle");

    // Passes a down request on the way up, serves it after reversing.
    do_reset();
    dn_r  = 4'b0010;
    in_r  = 4'b1000;
    rst_n = 1'b1;
    wait_for(4, 100, "pass_first_door");
    check("pass_first_door_pos", {d_pos, d_ud}, {4'b1000, 2'b01});
    wait_for(2, 20, "pass_reverse_run");
    check("pass_reverse_ud", 32'(d_ud), 32'(2'b10));
    wait_for(4, 100, "pass_second_door");
    check("pass_second_door_pos", {d_pos, d_ud}, {4'b0010, 2'b10});

    // Top floor with nothing pending settles to IDLE and stays put.
    do_reset();
    in_r  = 4'b1000;
    rst_n = 1'b1;
    wait_for(4, 100, "top_door");
    wait_for(0, 20, "top_idle");
    check("top_idle_state", dut_vec, ov(0, 4'b1000, 2'b00, 1'b0, 1'b0));
    repeat (5) tick();
    check("top_stays", dut_vec, ov(0, 4'b1000, 2'b00, 1'b0, 1'b0));

    // Reset in the middle of a downward run aborts without shifting.
    do_reset();
    in_r  = 4'b0100;
    rst_n = 1'b1;
    wait_for(4, 100, "abort_setup_door");
    wait_for(0, 20, "abort_setup_idle");
    in_r = 4'b0001;
    tick();
    check("abort_run_dn", dut_vec, ov(2, 4'b0100, 2'b10, 1'b0, 1'b1));
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_reset", dut_vec, ov(0, 4'b0001, 2'b00, 1'b0, 1'b0));
    in_r = '0;

    // Random requests, then a drain phase with no new requests.
    foreach (age[i]) age[i] = 0;
    max_age = 0;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      tick();
      if (cyc < 10000 && $urandom_range(9) == 0) begin
        b = int'($urandom_range(11));
        f = b % 4;
        if (f != m_floor) begin
          case (b / 4)
            0:       up_r[f] = 1'b1;
            1:       dn_r[f] = 1'b1;
            default: in_r[f] = 1'b1;
          endcase
        end
      end
      pend = {in_r, dn_r, up_r};
      for (int k = 0; k < 12; k++) begin
        age[k] = pend[k] ? age[k] + 1 : 0;
        if (age[k] > max_age) max_age = age[k];
      end
      if (cyc >= 10000 && pend == '0) break;
    end
    check("max_request_age_ok", 32'(max_age <= AGE_MAX), 32'd1);
    check("drain_all_served", 32'({in_r, dn_r, up_r}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
